mac_result_display: RTL

MAC_RESULT_DISPLAY -- requirements
Module: mac_result_display

---
 rtl/mac_disp_pkg.sv | 11 +
 rtl/hex7seg.sv | 32 +++
 rtl/mac_result_display.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mac_disp_pkg.sv
// Shared sizes and constants for the MAC result display.
package mac_disp_pkg;
  localparam int NUM_RESULTS = 8;
  localparam int RESULT_W    = 24;
  localparam int IDX_W       = 3;
  localparam int SEG_W       = 7;
  localparam int NUM_DIGITS  = RESULT_W / 4;

  localparam logic [SEG_W-1:0]       SEG_BLANK = 7'h7F;
  localparam logic [NUM_RESULTS-1:0] MASK_FULL = 8'hFF;
endpackage

// File: rtl/hex7seg.sv
// Nibble to active-low seven-segment glyph, segment order {g,f,e,d,c,b,a}.
module hex7seg
  import mac_disp_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  // glyph lookup, lowercase b and d
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/mac_result_display.sv
// Captures eight MAC results and shows the selected one on six hex digits.
// Optional MAC_DISP_AUTO_SCROLL_EN adds scroll_en and a self-advancing display index.
module mac_result_display
  import mac_disp_pkg::*;
#(
  parameter int SCROLL_DIV_LOG2 = 26
) (
  input  logic                   CLOCK_50,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [IDX_W-1:0]       res_idx,
  input  logic [RESULT_W-1:0]    res_data,
  input  logic [IDX_W-1:0]       sel,
`ifdef MAC_DISP_AUTO_SCROLL_EN
  input  logic                   scroll_en,
`endif
  output logic [SEG_W-1:0]       hex0,
  output logic [SEG_W-1:0]       hex1,
  output logic [SEG_W-1:0]       hex2,
  output logic [SEG_W-1:0]       hex3,
  output logic [SEG_W-1:0]       hex4,
  output logic [SEG_W-1:0]       hex5,
  output logic [NUM_RESULTS-1:0] valid_mask,
  output logic                   all_done
);

  logic [RESULT_W-1:0]    res_buf_r [NUM_RESULTS];
  logic [NUM_RESULTS-1:0] valid_mask_r;
  logic [NUM_RESULTS-1:0] mask_next_s;
  logic                   all_done_r;
  logic                   accept_s;
  logic [IDX_W-1:0]       disp_idx_s;
  logic [RESULT_W-1:0]    disp_data_s;
  logic [SEG_W-1:0]       seg_s [NUM_DIGITS];
  logic [SEG_W-1:0]       hex_r [NUM_DIGITS];

  assign res_ready  = !all_done_r;
  assign accept_s   = res_valid & res_ready;
  assign valid_mask = valid_mask_r;
  assign all_done   = all_done_r;

  // mask as it will look after an accepted capture
  always_comb begin
    mask_next_s = valid_mask_r;
    if (accept_s) begin
      mask_next_s = valid_mask_r | (8'd1 << res_idx);
    end else begin
      mask_next_s = valid_mask_r;
    end
  end

  // completion tracking; clr wins over a same-cycle capture
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      valid_mask_r <= 8'h00;
      all_done_r   <= 1'b0;
    end else if (clr) begin
      valid_mask_r <= 8'h00;
      all_done_r   <= 1'b0;
    end else if (accept_s) begin
      valid_mask_r <= mask_next_s;
      all_done_r   <= (mask_next_s == MASK_FULL);
    end
  end

  // result storage
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RESULTS; i++) begin
        res_buf_r[i] <= 24'h000000;
      end
    end else if (accept_s && !clr) begin
      res_buf_r[res_idx] <= res_data;
    end
  end

`ifdef MAC_DISP_AUTO_SCROLL_EN
  localparam logic [SCROLL_DIV_LOG2-1:0] PRESC_ONE = {{(SCROLL_DIV_LOG2-1){1'b0}}, 1'b1};
  localparam logic [SCROLL_DIV_LOG2-1:0] PRESC_MAX = {SCROLL_DIV_LOG2{1'b1}};

  logic [SCROLL_DIV_LOG2-1:0] presc_r;
  logic [IDX_W-1:0]           scroll_idx_r;

  // free-running prescaler; index steps once per full prescaler period
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      presc_r      <= '0;
      scroll_idx_r <= 3'd0;
    end else if (clr) begin
      presc_r      <= '0;
      scroll_idx_r <= 3'd0;
    end else begin
      presc_r <= presc_r + PRESC_ONE;
      if (presc_r == PRESC_MAX) begin
        scroll_idx_r <= scroll_idx_r + 3'd1;
      end
    end
  end

  // displayed index source
  always_comb begin
    disp_idx_s = sel;
    if (scroll_en) begin
      disp_idx_s = scroll_idx_r;
    end else begin
      disp_idx_s = sel;
    end
  end
`else
  assign disp_idx_s = sel;
`endif

  assign disp_data_s = res_buf_r[disp_idx_s];

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    hex7seg u_hex7seg (
      .nibble (disp_data_s[4*d +: 4]),
      .seg    (seg_s[d])
    );
  end

  // registered digits, blanked when the shown entry has not been captured
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hex_r[i] <= SEG_BLANK;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hex_r[i] <= valid_mask_r[disp_idx_s] ? seg_s[i] : SEG_BLANK;
      end
    end
  end

  assign hex0 = hex_r[0];
  assign hex1 = hex_r[1];
  assign hex2 = hex_r[2];
  assign hex3 = hex_r[3];
  assign hex4 = hex_r[4];
  assign hex5 = hex_r[5];
endmodule
